// File: rtl/conv_job_scheduler_if.sv
// conv_job_if: requester, engine and response signals around the conv job scheduler
interface conv_job_if #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 3
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic               eng_start;
  logic [7:0]         eng_idata;
  logic               eng_finish;
  logic [19:0]        eng_odata;
  logic               eng_rst;
  logic               resp_valid;
  logic [19:0]        resp_data;
  logic [ID_W-1:0]    resp_id;
  logic               job_done;
  logic               err;
  logic               busy;
  modport master (
    output req_valid, req_data, req_last, eng_finish, eng_odata,
    input  req_ready, grant, eng_start, eng_idata, eng_rst,
           resp_valid, resp_data, resp_id, job_done, err, busy
  );
  modport slave (
    input  req_valid, req_data, req_last, eng_finish, eng_odata,
    output req_ready, grant, eng_start, eng_idata, eng_rst,
           resp_valid, resp_data, resp_id, job_done, err, busy
  );
endinterface

// File: rtl/conv_job_scheduler.sv
// conv_job_scheduler: round-robin sharing of one 3x3 conv engine among N_REQ frame requesters
module conv_job_scheduler #(
  parameter int N_REQ     = 2,
  parameter int ID_W      = 3,
  parameter int IN_BEATS  = 36,
  parameter int OUT_BEATS = 16,
  parameter int TIMEOUT   = 255
) (
  input logic       clk,
  input logic       reset,
  conv_job_if.slave bus
);
  localparam int BW = $clog2(IN_BEATS > OUT_BEATS ? IN_BEATS : OUT_BEATS);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_DRAIN, S_CLEAR} state_t;
  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  owner_q, owner_d, rr_q, rr_d, pick;
  logic [BW-1:0]    beat_q, beat_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d, hit, own_valid, own_last, final_beat;
  logic [7:0]       own_byte;
  assign own_valid  = |(bus.req_valid & grant_q);
  assign own_last   = |(bus.req_last & grant_q);
  assign final_beat = beat_q == BW'(IN_BEATS - 1);
  // lowest valid index overall, overridden by the lowest valid index at or after rr_q
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (bus.req_valid[i]) begin hit = 1'b1; pick = ID_W'(i); end
    for (int i = N_REQ - 1; i >= 0; i--) if (bus.req_valid[i] && ID_W'(i) >= rr_q) pick = ID_W'(i);
  end
  always_comb begin
    own_byte = '0;
    for (int i = 0; i < N_REQ; i++) if (grant_q[i]) own_byte = bus.req_data[8*i +: 8];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (hit) begin
        grant_d = N_REQ'(1) << pick;
        owner_d = pick;
        err_d   = 1'b0;
        beat_d  = '0;
        state_d = S_LOAD;
      end
      S_LOAD: if (own_valid) begin
        beat_d = beat_q + BW'(1);
        // framing: last must be seen on the final beat and nowhere else
        if (final_beat != own_last) err_d = 1'b1;
        if (final_beat) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (bus.eng_finish) begin
          beat_d  = '0;
          state_d = S_DRAIN;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          grant_d = '0;
          state_d = S_CLEAR;
        end
      end
      S_DRAIN: begin
        beat_d = beat_q + BW'(1);
        if (beat_q == BW'(OUT_BEATS - 1)) begin
          grant_d = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        rr_d    = owner_q == ID_W'(N_REQ - 1) ? '0 : owner_q + ID_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready  = state_q == S_LOAD ? grant_q : '0;
    bus.grant      = grant_q;
    bus.eng_start  = state_q == S_LOAD && own_valid;
    bus.eng_idata  = own_byte;
    bus.eng_rst    = reset || state_q == S_CLEAR;
    bus.resp_valid = state_q == S_DRAIN;
    bus.resp_data  = bus.eng_odata;
    bus.resp_id    = owner_q;
    bus.job_done   = state_q == S_CLEAR;
    bus.err        = err_q;
    bus.busy       = state_q != S_IDLE;
  end
endmodule
